// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment bus receiver and driver-side checkers.
// Segment patterns are ordered abcdefg, bit 6 = a.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    // Indexed by the nibble the pattern represents.
    localparam seg_t SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCapture,
        StHold
    } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern decoder: maps an abcdefg pattern to its hex nibble,
// flagging table hits and the all-off blank pattern.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  seg_t       seg_i,
    output logic [3:0] nibble_o,
    output logic       hit_o,
    output logic       blank_o
);

    always_comb begin
        nibble_o = 4'h0;
        hit_o    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_TABLE[i]) begin
                nibble_o = 4'(i);
                hit_o    = 1'b1;
            end
        end
    end

    assign blank_o = (seg_i == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receiver for a multiplexed 7-segment bus: recovers the nibble, dp and validity per digit.
// Define SEG7_ACTIVE_LOW_EN to invert all bus inputs for common-anode boards.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic                    dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    err,
    output logic [2:0]              err_digit
);

    localparam int unsigned SW          = NUM_DIGITS + 8;
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [SW-1:0] samp_d, samp_q;
    logic [7:0]    cnt_d, cnt_q;
    state_e        state_d, state_q;

    logic [NUM_DIGITS-1:0] s_en;
    seg_t                  s_seg;
    logic                  s_dp;
    logic                  same, settled, capture;
    logic [2:0]            idx;
    logic [3:0]            nibble;
    logic                  hit, blank;

    logic [4*NUM_DIGITS-1:0] value_d, value_q;
    logic [NUM_DIGITS-1:0]   dp_d, dp_q, valid_d, valid_q, mask_d, mask_q, mask_next;
    logic                    frame_d, frame_q, err_d, err_q;
    logic [2:0]              err_digit_d, err_digit_q;

`ifdef SEG7_ACTIVE_LOW_EN
    assign samp_d = ~{digit_en, seg_in, dp_in};
`else
    assign samp_d = {digit_en, seg_in, dp_in};
`endif

    assign s_en  = samp_q[SW-1:8];
    assign s_seg = samp_q[7:1];
    assign s_dp  = samp_q[0];

    // cnt_q = number of identical one-hot samples registered so far, minus one.
    assign same = (samp_d == samp_q) && $onehot(samp_d[SW-1:8]);

    always_comb begin
        cnt_d = 8'd0;
        if (same) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end

    assign settled = (cnt_q == SETTLE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A cnt_q of zero outside IDLE means the sample just changed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (settled)             state_d = StCapture;
                else if ($onehot(s_en))  state_d = StSettle;
            end
            StSettle: begin
                if (settled)             state_d = StCapture;
                else if (cnt_q == 8'd0)  state_d = StIdle;
            end
            StCapture: state_d = (cnt_q == 8'd0) ? StIdle : StHold;
            StHold: begin
                if (cnt_q == 8'd0)       state_d = StIdle;
            end
            default:                     state_d = StIdle;
        endcase
    end

    assign capture = ((state_q == StIdle) || (state_q == StSettle)) && settled;

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s_en[i]) idx = 3'(i);
        end
    end

    seg7_pattern_decode u_decode (
        .seg_i    (s_seg),
        .nibble_o (nibble),
        .hit_o    (hit),
        .blank_o  (blank)
    );

    assign mask_next = mask_q | s_en;

    always_comb begin
        value_d     = value_q;
        dp_d        = dp_q;
        valid_d     = valid_q;
        mask_d      = mask_q;
        frame_d     = 1'b0;
        err_d       = 1'b0;
        err_digit_d = err_digit_q;
        if (capture) begin
            dp_d[idx] = s_dp;
            if (hit) begin
                value_d[4*idx +: 4] = nibble;
                valid_d[idx]        = 1'b1;
            end else begin
                valid_d[idx] = 1'b0;
                if (!blank) begin
                    err_d       = 1'b1;
                    err_digit_d = idx;
                end
            end
            if (&mask_next) begin
                frame_d = 1'b1;
                mask_d  = '0;
            end else begin
                mask_d = mask_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q      <= '0;
            cnt_q       <= 8'd0;
            value_q     <= '0;
            dp_q        <= '0;
            valid_q     <= '0;
            mask_q      <= '0;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= 3'd0;
        end else begin
            samp_q      <= samp_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            dp_q        <= dp_d;
            valid_q     <= valid_d;
            mask_q      <= mask_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign value_out   = value_q;
    assign dp_out      = dp_q;
    assign digit_valid = valid_q;
    assign frame_valid = frame_q;
    assign err         = err_q;
    assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (NUM_DIGITS=4, SETTLE_CYCLES=4).
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic        dp_in;
    logic [3:0]  digit_en;
    logic [15:0] value_out;
    logic [3:0]  dp_out;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        err;
    logic [2:0]  err_digit;

    int n_run = 0;
    int n_fail = 0;
    int err_seen = 0;
    int frame_seen = 0;

    seg7_scan_decoder #(
        .NUM_DIGITS    (4),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .value_out   (value_out),
        .dp_out      (dp_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .err         (err),
        .err_digit   (err_digit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && err)         err_seen   <= err_seen + 1;
        if (!rst && frame_valid) frame_seen <= frame_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] en, input logic [6:0] s, input logic d);
        digit_en = en;
        seg_in   = s;
        dp_in    = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'b0000, 7'h00, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b0010, 7'h30, 1'b1);
        tick();
        tick();
        tick();
        n_run++;
        if (value_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_value: got %h want %h", value_out, 16'h0000);
        end
        n_run++;
        if ({dp_out, digit_valid} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dp_valid: got %b want %b", {dp_out, digit_valid}, 8'h00);
        end
        n_run++;
        if ({frame_valid, err, err_digit} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want %b", {frame_valid, err, err_digit}, 5'b0);
        end
        rst = 1'b0;
    endtask

    task automatic test_static();
        int e0;
        do_reset();
        e0 = err_seen;
        drive(4'b0001, 7'h7E, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            logic [3:0] exp_v;
            tick();
            exp_v = (e >= 5) ? 4'b0001 : 4'b0000;
            n_run++;
            if (digit_valid !== exp_v) begin
                n_fail++;
                $display("FAIL static_valid edge %0d: got %b want %b", e, digit_valid, exp_v);
            end
        end
        n_run++;
        if (value_out[3:0] !== 4'h0) begin
            n_fail++;
            $display("FAIL static_value: got %h want %h", value_out[3:0], 4'h0);
        end
        n_run++;
        if (err_seen !== e0) begin
            n_fail++;
            $display("FAIL static_err: got %0d pulses want 0", err_seen - e0);
        end
    endtask

    task automatic test_full_frame();
        logic [6:0] segs [4];
        int f0;
        segs = '{7'h5B, 7'h1F, 7'h4E, 7'h47};
        do_reset();
        f0 = frame_seen;
        for (int d = 0; d < 4; d++) begin
            drive(4'(1 << d), segs[d], (d == 2));
            for (int e = 1; e <= 6; e++) begin
                logic exp_fv;
                tick();
                exp_fv = (d == 3) && (e == 5);
                n_run++;
                if (frame_valid !== exp_fv) begin
                    n_fail++;
                    $display("FAIL frame_pulse digit %0d edge %0d: got %b want %b",
                             d, e, frame_valid, exp_fv);
                end
            end
        end
        n_run++;
        if (value_out !== 16'hFCB5) begin
            n_fail++;
            $display("FAIL frame_value: got %h want %h", value_out, 16'hFCB5);
        end
        n_run++;
        if (digit_valid !== 4'b1111) begin
            n_fail++;
            $display("FAIL frame_valid_mask: got %b want %b", digit_valid, 4'b1111);
        end
        n_run++;
        if (dp_out !== 4'b0100) begin
            n_fail++;
            $display("FAIL frame_dp: got %b want %b", dp_out, 4'b0100);
        end
        n_run++;
        if (frame_seen - f0 !== 1) begin
            n_fail++;
            $display("FAIL frame_count: got %0d want 1", frame_seen - f0);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        drive(4'b0010, 7'h6D, 1'b0);
        repeat (6) tick();
        n_run++;
        if (value_out !== 16'h0020) begin
            n_fail++;
            $display("FAIL glitch_setup: got %h want %h", value_out, 16'h0020);
        end
        for (int k = 0; k < 8; k++) begin
            drive(4'b0010, (k % 2 == 1) ? 7'h33 : 7'h30, 1'b0);
            tick();
            tick();
        end
        n_run++;
        if (value_out !== 16'h0020) begin
            n_fail++;
            $display("FAIL glitch_value: got %h want %h", value_out, 16'h0020);
        end
        n_run++;
        if (digit_valid !== 4'b0010) begin
            n_fail++;
            $display("FAIL glitch_valid: got %b want %b", digit_valid, 4'b0010);
        end
    endtask

    task automatic test_illegal_blank();
        int e0;
        do_reset();
        drive(4'b0100, 7'h79, 1'b0);
        repeat (6) tick();
        n_run++;
        if ({digit_valid, value_out[11:8]} !== {4'b0100, 4'h3}) begin
            n_fail++;
            $display("FAIL illegal_setup: got %b/%h want 0100/3", digit_valid, value_out[11:8]);
        end
        e0 = err_seen;
        drive(4'b0100, 7'h01, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            logic exp_err;
            tick();
            exp_err = (e == 5);
            n_run++;
            if (err !== exp_err) begin
                n_fail++;
                $display("FAIL illegal_err edge %0d: got %b want %b", e, err, exp_err);
            end
            if (e == 5) begin
                n_run++;
                if (err_digit !== 3'd2) begin
                    n_fail++;
                    $display("FAIL illegal_err_digit: got %0d want 2", err_digit);
                end
            end
        end
        n_run++;
        if ({digit_valid, value_out[11:8]} !== {4'b0000, 4'h3}) begin
            n_fail++;
            $display("FAIL illegal_outputs: got %b/%h want 0000/3", digit_valid, value_out[11:8]);
        end
        drive(4'b0100, 7'h00, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_run++;
            if (err !== 1'b0) begin
                n_fail++;
                $display("FAIL blank_err edge %0d: got %b want 0", e, err);
            end
        end
        n_run++;
        if ({digit_valid, value_out[11:8]} !== {4'b0000, 4'h3}) begin
            n_fail++;
            $display("FAIL blank_outputs: got %b/%h want 0000/3", digit_valid, value_out[11:8]);
        end
        n_run++;
        if (err_seen - e0 !== 1) begin
            n_fail++;
            $display("FAIL illegal_err_count: got %0d want 1", err_seen - e0);
        end
    endtask

    task automatic test_multi_hot();
        int e0;
        int f0;
        do_reset();
        e0 = err_seen;
        f0 = frame_seen;
        drive(4'b0011, 7'h7E, 1'b1);
        repeat (20) tick();
        n_run++;
        if ({digit_valid, dp_out} !== 8'h00) begin
            n_fail++;
            $display("FAIL multi_hot: got %b want 00000000", {digit_valid, dp_out});
        end
        drive(4'b0000, 7'h7E, 1'b1);
        repeat (10) tick();
        n_run++;
        if ({digit_valid, dp_out} !== 8'h00) begin
            n_fail++;
            $display("FAIL zero_hot: got %b want 00000000", {digit_valid, dp_out});
        end
        n_run++;
        if ((err_seen != e0) || (frame_seen != f0)) begin
            n_fail++;
            $display("FAIL multi_hot_pulses: got err %0d frame %0d want 0 0",
                     err_seen - e0, frame_seen - f0);
        end
    endtask

    task automatic test_reset_mid_settle();
        do_reset();
        drive(4'b0010, 7'h5B, 1'b1);
        repeat (6) tick();
        n_run++;
        if ({digit_valid, dp_out} !== 8'b0010_0010) begin
            n_fail++;
            $display("FAIL midrst_setup: got %b want 00100010", {digit_valid, dp_out});
        end
        drive(4'b0001, 7'h30, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_run++;
        if ({value_out, dp_out, digit_valid, frame_valid, err, err_digit} !== 29'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h want 0",
                     {value_out, dp_out, digit_valid, frame_valid, err, err_digit});
        end
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            logic [3:0] exp_v;
            tick();
            exp_v = (e >= 5) ? 4'b0001 : 4'b0000;
            n_run++;
            if (digit_valid !== exp_v) begin
                n_fail++;
                $display("FAIL midrst_valid edge %0d: got %b want %b", e, digit_valid, exp_v);
            end
        end
        n_run++;
        if (value_out !== 16'h0001) begin
            n_fail++;
            $display("FAIL midrst_value: got %h want %h", value_out, 16'h0001);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(4'b0000, 7'h00, 1'b0);
        test_reset();
        test_static();
        test_full_frame();
        test_glitch();
        test_illegal_blank();
        test_multi_hot();
        test_reset_mid_settle();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
